ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage 16-bit core. It sits directly upstream of the ALU and feeds its A, B, op and imm inputs.
- Resolves RAW hazards: forwards from EX/MEM and MEM/WB, and detects load-use hazards, stalling ID/IF and inserting a bubble.
- Holds the architectural Z/V/N flag register, which captures the ALU Flag output for the branch unit.

Parameters:
- DSIZE, 16, datapath width; must match the ALU.
- AW, 3, register address width; r0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  3  ALU opcode.
- id_shamt  in  4  shift/rotate amount.
- id_ext_imm  in  DSIZE  sign-extended immediate.
- id_bsel_imm  in  1  1 = B operand is id_ext_imm, 0 = rs2.
- id_rs1_addr, id_rs2_addr  in  AW each  source register addresses.
- id_rs1_used, id_rs2_used  in  1 each  source is actually read.
- id_rs1_data, id_rs2_data  in  DSIZE each  register file read data.
- id_wr_en  in  1  writes rd.
- id_rd_addr  in  AW  destination register.
- id_is_load  in  1  load instruction.
- id_set_flags  in  1  instruction updates flags.
- flush  in  1  taken branch; kill the ID instruction.
- mem_wr_en, mem_rd_addr, mem_result  in  1/AW/DSIZE  EX/MEM forward source.
- wb_wr_en, wb_rd_addr, wb_result  in  1/AW/DSIZE  MEM/WB forward source.
- alu_flag  in  3  ALU Flag {Z,V,N}.
- stall  out  1  hold IF/ID this cycle.
- alu_a, alu_b  out  DSIZE each  forwarded operands to the ALU.
- alu_op  out  3  to the ALU.
- alu_imm  out  4  to the ALU.
- ex_valid, ex_wr_en, ex_is_load  out  1 each  EX stage controls to EX/MEM.
- ex_rd_addr  out  AW  EX destination register.
- ex_store_data  out  DSIZE  forwarded rs2 value, for stores.
- flags_q  out  3  registered {Z,V,N}.

Behaviour:
- Reset (rst=1 at an edge): all EX registers are cleared and flags_q=0.
  - Outputs after reset: ex_valid=0, ex_wr_en=0, ex_is_load=0, alu_op=0, alu_imm=0, alu_a=0, alu_b=0.
  - rst has priority over every other input. Reset mid-stall drops the stalled instruction; upstream re-fetches.
- Hazard:
  - hz = ex_valid & ex_is_load & ex_rd_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
  - stall = hz & id_valid & ~flush. This output is combinational.
- Register update priority is rst > flush > stall > load:
  - flush or stall: load a bubble (valid, wr_en, is_load and set_flags all 0; data fields don't-care, held at 0).
  - Otherwise: capture all id_* fields. valid=id_valid, and the control bits are ANDed with id_valid.
- Latency: one cycle from ID to the ALU inputs. No stall beyond one cycle is generated for a single load-use.
- Forwarding is combinational on registered source addresses and data, and is computed for each source s = rs1 and rs2:
  - Forward mem_result if mem_wr_en, mem_rd_addr==s and s!=0.
  - Otherwise forward wb_result if wb_wr_en, wb_rd_addr==s and s!=0.
  - Otherwise use the registered register-file data.
  - EX/MEM wins over MEM/WB when both match. Address 0 always yields 0.
- Operand outputs:
  - alu_a = fwd(rs1).
  - ex_store_data = fwd(rs2).
  - alu_b = registered bsel_imm ? ext_imm : fwd(rs2).
- Flags:
  - On an edge with ex_valid & set_flags: flags_q <= alu_flag.
  - Bubbles, flush and stall never alter flags_q. The ALU result of the same cycle is captured, so flags are visible the cycle after EX.
- flush and hz in the same cycle: a bubble is inserted and stall=0.

Decomposition:
- Shared package/define file holds:
  - DSIZE and AW.
  - ALU opcode constants: ADD=000, SUB=001, AND=010, OR=011, SLL=100, SRL=101, SRA=110, RL=111.
  - Flag bit indices: Z=2, V=1, N=0.
- One natural sub-module: fwd_mux (one instance per source operand). It takes the source address, register data and both forward ports, and returns the selected value.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 -> ex_valid=0, flags_q=000, stall=0, alu_a=alu_b=0.
- Back-to-back ADD r1=r2+r3, then SUB r4=r1-r2 (mem_wr_en=1, mem_rd_addr=1, mem_result=16'h0005, wb also rd=1 with 16'h0009) -> alu_a=16'h0005, i.e. EX/MEM priority.
- Load-use: EX holds a load to r3; ID reads r3 as rs2 -> stall=1 for exactly one cycle, next ex_valid=0. The following cycle, with wb_rd_addr=3 and wb_result=16'h00AA, gives alu_b=16'h00AA.
- Load-use with flush=1 in the same cycle -> stall=0, and EX is a bubble next cycle.
- r0 forwarding: mem_wr_en=1, mem_rd_addr=0, mem_result=16'hFFFF; ID reads r0 -> alu_a=0.
- Flags: SUB with set_flags and alu_flag=100 -> flags_q=100 next cycle. Then a bubble with alu_flag=001 -> flags_q stays 100. Then SLL with set_flags=0 -> flags_q unchanged.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage of the 16-bit core:
// datapath widths, ALU opcode encoding and flag bit positions.
package ex_operand_stage_pkg;

  localparam int DSIZE = 16;
  localparam int AW    = 3;

  // ALU opcodes as decoded in ID and consumed by the ALU.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_RL  = 3'b111
  } alu_op_e;

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand bypass selector for one source register. The youngest
// producer (EX/MEM) wins over MEM/WB, and r0 always reads as zero
// no matter what a forward port claims to have written to it.
module ex_operand_stage_fwd_mux #(
  parameter int DSIZE = 16,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]    src_addr,
  input  logic [DSIZE-1:0] reg_data,
  input  logic             mem_wr_en,
  input  logic [AW-1:0]    mem_rd_addr,
  input  logic [DSIZE-1:0] mem_result,
  input  logic             wb_wr_en,
  input  logic [AW-1:0]    wb_rd_addr,
  input  logic [DSIZE-1:0] wb_result,
  output logic [DSIZE-1:0] fwd_data
);

  // Pick the most recent in-flight value for this source, else the RF read.
  always_comb begin
    fwd_data = reg_data;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (mem_wr_en && (mem_rd_addr == src_addr)) begin
      fwd_data = mem_result;
    end else if (wb_wr_en && (wb_rd_addr == src_addr)) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW hazard handling. Holds the decoded
// instruction for one cycle in front of the ALU, bypasses results from
// EX/MEM and MEM/WB, stalls ID/IF on a load-use and owns the Z/V/N flags.
module ex_operand_stage #(
  parameter int DSIZE = ex_operand_stage_pkg::DSIZE,
  parameter int AW    = ex_operand_stage_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_op,
  input  logic [3:0]       id_shamt,
  input  logic [DSIZE-1:0] id_ext_imm,
  input  logic             id_bsel_imm,
  input  logic [AW-1:0]    id_rs1_addr,
  input  logic [AW-1:0]    id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [DSIZE-1:0] id_rs1_data,
  input  logic [DSIZE-1:0] id_rs2_data,
  input  logic             id_wr_en,
  input  logic [AW-1:0]    id_rd_addr,
  input  logic             id_is_load,
  input  logic             id_set_flags,
  input  logic             flush,
  input  logic             mem_wr_en,
  input  logic [AW-1:0]    mem_rd_addr,
  input  logic [DSIZE-1:0] mem_result,
  input  logic             wb_wr_en,
  input  logic [AW-1:0]    wb_rd_addr,
  input  logic [DSIZE-1:0] wb_result,
  input  logic [2:0]       alu_flag,
  output logic             stall,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_imm,
  output logic             ex_valid,
  output logic             ex_wr_en,
  output logic             ex_is_load,
  output logic [AW-1:0]    ex_rd_addr,
  output logic [DSIZE-1:0] ex_store_data,
  output logic [2:0]       flags_q
);

  import ex_operand_stage_pkg::*;

  logic             ex_set_flags;
  logic             ex_bsel_imm;
  logic [DSIZE-1:0] ex_ext_imm;
  logic [AW-1:0]    ex_rs1_addr;
  logic [AW-1:0]    ex_rs2_addr;
  logic [DSIZE-1:0] ex_rs1_data;
  logic [DSIZE-1:0] ex_rs2_data;
  logic [DSIZE-1:0] fwd_rs1;
  logic [DSIZE-1:0] fwd_rs2;
  logic             hz;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             insert_bubble;

  // A load in EX cannot be bypassed to ID in time; detect a reader of its rd.
  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    hz      = ex_valid && ex_is_load && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);
    // A taken branch kills ID anyway, so a flush never needs a stall.
    stall   = hz && id_valid && !flush;
    insert_bubble = flush || stall;
  end

  // ID/EX register: reset, then bubble on flush/stall, else capture ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_wr_en     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_set_flags <= 1'b0;
      alu_op       <= ALU_ADD;
      alu_imm      <= '0;
      ex_bsel_imm  <= 1'b0;
      ex_ext_imm   <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rd_addr   <= '0;
    end else if (insert_bubble) begin
      ex_valid     <= 1'b0;
      ex_wr_en     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_set_flags <= 1'b0;
      alu_op       <= ALU_ADD;
      alu_imm      <= '0;
      ex_bsel_imm  <= 1'b0;
      ex_ext_imm   <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rd_addr   <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_wr_en     <= id_wr_en && id_valid;
      ex_is_load   <= id_is_load && id_valid;
      ex_set_flags <= id_set_flags && id_valid;
      alu_op       <= id_op;
      alu_imm      <= id_shamt;
      ex_bsel_imm  <= id_bsel_imm;
      ex_ext_imm   <= id_ext_imm;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_rd_addr   <= id_rd_addr;
    end
  end

  // Capture the ALU flags of a real flag-setting instruction sitting in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (ex_valid && ex_set_flags) begin
      flags_q[FLAG_Z] <= alu_flag[FLAG_Z];
      flags_q[FLAG_V] <= alu_flag[FLAG_V];
      flags_q[FLAG_N] <= alu_flag[FLAG_N];
    end
  end

  ex_operand_stage_fwd_mux #(
    .DSIZE (DSIZE),
    .AW    (AW)
  ) u_fwd_rs1 (
    .src_addr    (ex_rs1_addr),
    .reg_data    (ex_rs1_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_result  (mem_result),
    .wb_wr_en    (wb_wr_en),
    .wb_rd_addr  (wb_rd_addr),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs1)
  );

  ex_operand_stage_fwd_mux #(
    .DSIZE (DSIZE),
    .AW    (AW)
  ) u_fwd_rs2 (
    .src_addr    (ex_rs2_addr),
    .reg_data    (ex_rs2_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_result  (mem_result),
    .wb_wr_en    (wb_wr_en),
    .wb_rd_addr  (wb_rd_addr),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs2)
  );

  // Stores always need the real rs2 value even when B takes the immediate.
  always_comb begin
    alu_a         = fwd_rs1;
    ex_store_data = fwd_rs2;
    alu_b         = ex_bsel_imm ? ex_ext_imm : fwd_rs2;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a
// randomized run, all compared against an instruction-level model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_op;
  logic [3:0]  id_shamt;
  logic [15:0] id_ext_imm;
  logic        id_bsel_imm;
  logic [2:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used;
  logic [15:0] id_rs1_data, id_rs2_data;
  logic        id_wr_en;
  logic [2:0]  id_rd_addr;
  logic        id_is_load, id_set_flags, flush;
  logic        mem_wr_en;
  logic [2:0]  mem_rd_addr;
  logic [15:0] mem_result;
  logic        wb_wr_en;
  logic [2:0]  wb_rd_addr;
  logic [15:0] wb_result;
  logic [2:0]  alu_flag;
  logic        stall;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  alu_imm;
  logic        ex_valid, ex_wr_en, ex_is_load;
  logic [2:0]  ex_rd_addr;
  logic [15:0] ex_store_data;
  logic [2:0]  flags_q;

  int vectors = 0;
  int miscompares = 0;

  // Instruction currently believed to be in EX, plus the flag register.
  typedef struct packed {
    logic        valid, wr, load, setf, bsel;
    logic [2:0]  op;
    logic [3:0]  shamt;
    logic [15:0] imm, d1, d2;
    logic [2:0]  rs1, rs2, rd;
  } ex_t;
  ex_t        m;
  logic [2:0] mflags;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_shamt(id_shamt),
    .id_ext_imm(id_ext_imm), .id_bsel_imm(id_bsel_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_wr_en(id_wr_en), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
    .id_set_flags(id_set_flags), .flush(flush),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .alu_flag(alu_flag), .stall(stall), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_imm(alu_imm), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data),
    .flags_q(flags_q)
  );

  // Value a source register really holds right now, seen from EX.
  function automatic logic [15:0] model_fwd(input logic [2:0] a, input logic [15:0] d);
    if (a == 3'd0) return 16'h0000;
    if (mem_wr_en && mem_rd_addr == a) return mem_result;
    if (wb_wr_en && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  function automatic logic model_stall();
    logic reads;
    reads = (id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd);
    return m.valid && m.load && (m.rd != 3'd0) && reads && id_valid && !flush;
  endfunction

  function automatic logic [64:0] model_outputs();
    logic [15:0] sd;
    sd = model_fwd(m.rs2, m.d2);
    return {m.valid, m.wr, m.load, m.rd, m.op, m.shamt,
            model_fwd(m.rs1, m.d1), (m.bsel ? m.imm : sd), sd, mflags};
  endfunction

  // One clock edge, applied to the model with the inputs present at the edge.
  task automatic tick();
    logic st;
    st = model_stall();
    @(posedge clk);
    if (rst) begin
      m = '0;
      mflags = 3'b000;
    end else begin
      if (m.valid && m.setf) mflags = alu_flag;
      if (flush || st) begin
        m = '0;
      end else begin
        m.valid = id_valid;
        m.wr    = id_wr_en && id_valid;
        m.load  = id_is_load && id_valid;
        m.setf  = id_set_flags && id_valid;
        m.bsel  = id_bsel_imm;
        m.op    = id_op;
        m.shamt = id_shamt;
        m.imm   = id_ext_imm;
        m.d1    = id_rs1_data;
        m.d2    = id_rs2_data;
        m.rs1   = id_rs1_addr;
        m.rs2   = id_rs2_addr;
        m.rd    = id_rd_addr;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; id_valid = 1'b0; id_op = 3'd0; id_shamt = 4'd0; id_ext_imm = 16'h0;
    id_bsel_imm = 1'b0; id_rs1_addr = 3'd0; id_rs2_addr = 3'd0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; id_rs1_data = 16'h0; id_rs2_data = 16'h0; id_wr_en = 1'b0;
    id_rd_addr = 3'd0; id_is_load = 1'b0; id_set_flags = 1'b0; flush = 1'b0;
    mem_wr_en = 1'b0; mem_rd_addr = 3'd0; mem_result = 16'h0;
    wb_wr_en = 1'b0; wb_rd_addr = 3'd0; wb_result = 16'h0; alu_flag = 3'd0;
  endtask

  task automatic set_id(input logic [2:0] op, input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2, input logic bsel,
                        input logic wr, input logic [2:0] rd, input logic ld, input logic sf);
    id_valid = 1'b1; id_op = op; id_shamt = 4'($urandom); id_ext_imm = 16'($urandom);
    id_rs1_addr = rs1; id_rs1_used = u1; id_rs1_data = 16'($urandom);
    id_rs2_addr = rs2; id_rs2_used = u2; id_rs2_data = 16'($urandom);
    id_bsel_imm = bsel; id_wr_en = wr; id_rd_addr = rd; id_is_load = ld; id_set_flags = sf;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    set_id(3'b001, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
    alu_flag = 3'b111;
    tick();
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ex_valid: got %b want 0", ex_valid); end
    vectors++; if (flags_q !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", flags_q); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    vectors++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_operands: got a=%h b=%h want 0/0", alu_a, alu_b); end
    vectors++; if (alu_op !== 3'd0 || alu_imm !== 4'd0 || ex_wr_en !== 1'b0 || ex_is_load !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl: got op=%h imm=%h wr=%b ld=%b want all 0", alu_op, alu_imm, ex_wr_en, ex_is_load);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_idle();
    set_id(3'b000, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    vectors++; if (alu_a !== model_fwd(m.rs1, m.d1) || alu_b !== model_fwd(m.rs2, m.d2)) begin
      miscompares++; $display("[TB] FAIL b2b_add_operands: got a=%h b=%h want a=%h b=%h", alu_a, alu_b, m.d1, m.d2);
    end
    set_id(3'b001, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    tick();
    mem_wr_en = 1'b1; mem_rd_addr = 3'd1; mem_result = 16'h0005;
    wb_wr_en = 1'b1; wb_rd_addr = 3'd1; wb_result = 16'h0009;
    #1;
    vectors++; if (alu_a !== 16'h0005) begin miscompares++; $display("[TB] FAIL b2b_mem_priority: got alu_a=%h want 0005", alu_a); end
    vectors++; if (alu_op !== 3'b001 || ex_rd_addr !== 3'd4 || ex_wr_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL b2b_sub_ctrl: got op=%h rd=%h wr=%b want 1/4/1", alu_op, ex_rd_addr, ex_wr_en);
    end
    mem_wr_en = 1'b0;
    #1;
    vectors++; if (alu_a !== 16'h0009) begin miscompares++; $display("[TB] FAIL b2b_wb_forward: got alu_a=%h want 0009", alu_a); end
  endtask

  task automatic test_load_use();
    drive_idle();
    set_id(3'b000, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    set_id(3'b000, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL loaduse_stall: got %b want 1", stall); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL loaduse_bubble: got ex_valid=%b want 0", ex_valid); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL loaduse_one_cycle: got stall=%b want 0", stall); end
    wb_wr_en = 1'b1; wb_rd_addr = 3'd3; wb_result = 16'h00AA;
    tick();
    vectors++; if (alu_b !== 16'h00AA || ex_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL loaduse_wb_fwd: got alu_b=%h valid=%b want 00aa/1", alu_b, ex_valid);
    end
  endtask

  task automatic test_load_use_flush();
    drive_idle();
    set_id(3'b000, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    set_id(3'b010, 3'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_stall: got %b want 0", stall); end
    tick();
    vectors++; if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_bubble: got valid=%b wr=%b want 0/0", ex_valid, ex_wr_en);
    end
    flush = 1'b0;
  endtask

  task automatic test_r0_forward();
    drive_idle();
    set_id(3'b011, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    id_rs1_data = 16'h1234; id_rs2_data = 16'h4321;
    tick();
    mem_wr_en = 1'b1; mem_rd_addr = 3'd0; mem_result = 16'hFFFF;
    wb_wr_en = 1'b1; wb_rd_addr = 3'd0; wb_result = 16'hFFFF;
    #1;
    vectors++; if (alu_a !== 16'h0000) begin miscompares++; $display("[TB] FAIL r0_alu_a: got %h want 0000", alu_a); end
    vectors++; if (ex_store_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL r0_store_data: got %h want 0000", ex_store_data); end
  endtask

  task automatic test_flags();
    drive_idle();
    set_id(3'b001, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    tick();
    drive_idle();
    alu_flag = 3'b100;
    tick();
    vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("[TB] FAIL flags_capture: got %b want 100", flags_q); end
    alu_flag = 3'b001;
    set_id(3'b100, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("[TB] FAIL flags_bubble_hold: got %b want 100", flags_q); end
    drive_idle();
    alu_flag = 3'b011;
    tick();
    vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("[TB] FAIL flags_noset_hold: got %b want 100", flags_q); end
  endtask

  task automatic test_random();
    logic [64:0] exp_o, got_o;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id(3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
      id_valid = ($urandom_range(0, 4) != 0);
      mem_wr_en = 1'($urandom); mem_rd_addr = 3'($urandom); mem_result = 16'($urandom);
      wb_wr_en = 1'($urandom); wb_rd_addr = 3'($urandom); wb_result = 16'($urandom);
      alu_flag = 3'($urandom);
      #1;
      vectors++; if (stall !== model_stall()) begin
        miscompares++; $display("[TB] FAIL rand_stall[%0d]: got %b want %b", i, stall, model_stall());
      end
      tick();
      exp_o = model_outputs();
      got_o = {ex_valid, ex_wr_en, ex_is_load, ex_rd_addr, alu_op, alu_imm,
               alu_a, alu_b, ex_store_data, flags_q};
      vectors++; if (got_o !== exp_o) begin
        miscompares++; $display("[TB] FAIL rand_outputs[%0d]: got %h want %h", i, got_o, exp_o);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m = '0;
    mflags = 3'b000;
    drive_idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_load_use_flush();
    test_r0_forward();
    test_flags();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
